wb_burst_master: RTL and testbench

- Wishbone B3 pipelined-burst initiator; drives the WB slave side of the SDRAM port (`wb_port`) from a simple command/data-stream interface.
- Issues classic single cycles or incrementing bursts (CTI 010/111) with linear or wrap4/8/16 BTE addressing.
- Used by DMA/framebuffer/test engines that need SDRAM bandwidth without hand-built WB sequencing.

---
 rtl/wb_burst_master_if.sv | 24 ++
 rtl/wb_burst_master.sv | 206 ++++++++++++++++++++
 tb/tb_wb_burst_master.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_burst_master_if.sv
// Wishbone B3 bus bundle between the burst initiator and the SDRAM port's slave side.
interface wb_burst_master_if;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B3 incrementing-burst initiator (linear / wrap4/8/16) driven by a
// command plus write-data stream; read data returns as one-cycle pulses.
//
// state     | meaning
// S_IDLE    | no cycle open, cmd_ready high
// S_RD      | read burst, stb held until the final ack
// S_WR      | write beat on the bus, waiting for ack
// S_WR_WAIT | write cycle open, stb low, waiting for wdat_valid
module wb_burst_master #(
    parameter int LEN_WIDTH = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [31:0]          cmd_adr,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic [1:0]           cmd_bte,
    input  logic                 wdat_valid,
    output logic                 wdat_ready,
    input  logic [31:0]          wdat,
    input  logic [3:0]           wsel,
    output logic                 rdat_valid,
    output logic [31:0]          rdat,
    output logic                 done,
    output logic                 err,
    wb_burst_master_if.master    wb
);

    localparam int TW     = $clog2(TIMEOUT + 2);
    localparam int TO_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_WR_WAIT} state_t;

    state_t               state_q, state_d;
    logic [31:0]          adr_q, adr_d;
    logic [31:0]          dat_q, dat_d;
    logic [3:0]           sel_q, sel_d;
    logic                 we_q, we_d;
    logic                 cyc_q, cyc_d;
    logic                 stb_q, stb_d;
    logic [2:0]           cti_q, cti_d;
    logic [1:0]           bte_q, bte_d;
    logic [LEN_WIDTH-1:0] beats_q, beats_d;
    logic [TW-1:0]        to_cnt_q, to_cnt_d;
    logic [31:0]          rdat_q, rdat_d;
    logic                 rdat_valid_q, rdat_valid_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic stall, beat_ok, abort, last_beat;

    // Wrap modes keep the carry inside the wrap field so the burst stays in its aligned block.
    function automatic logic [31:0] adr_next(input logic [31:0] a, input logic [1:0] bte);
        case (bte)
            2'b01:   adr_next = {a[31:4], a[3:0] + 4'd4};
            2'b10:   adr_next = {a[31:5], a[4:0] + 5'd4};
            2'b11:   adr_next = {a[31:6], a[5:0] + 6'd4};
            default: adr_next = a + 32'd4;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        we_d         = we_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        cti_d        = cti_q;
        bte_d        = bte_q;
        beats_d      = beats_q;
        rdat_d       = rdat_q;
        rdat_valid_d = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        wdat_ready   = 1'b0;
        cmd_ready    = (state_q == S_IDLE);

        stall     = stb_q & ~wb.wb_ack_i & ~wb.wb_err_i;
        beat_ok   = stb_q & wb.wb_ack_i & ~wb.wb_err_i;
        abort     = stb_q & (wb.wb_err_i |
                    ((TIMEOUT != 0) && stall && (to_cnt_q == TW'(TO_LIM))));
        last_beat = (beats_q == '0);

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    bte_d   = cmd_bte;
                    adr_d   = cmd_adr & 32'hFFFF_FFFC;
                    beats_d = cmd_len;
                    cyc_d   = 1'b1;
                    cti_d   = (cmd_len == '0) ? 3'b000 : 3'b010;
                    stb_d   = ~cmd_we;
                    state_d = cmd_we ? S_WR_WAIT : S_RD;
                end
            end
            S_RD: begin
                if (beat_ok) begin
                    rdat_d       = wb.wb_dat_i;
                    rdat_valid_d = 1'b1;
                end
            end
            S_WR_WAIT: begin
                wdat_ready = 1'b1;
                if (wdat_valid) begin
                    dat_d   = wdat;
                    sel_d   = wsel;
                    stb_d   = 1'b1;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                wdat_ready = beat_ok & ~last_beat;
                if (beat_ok && !last_beat) begin
                    if (wdat_valid) begin
                        dat_d = wdat;
                        sel_d = wsel;
                    end else begin
                        stb_d   = 1'b0;
                        state_d = S_WR_WAIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Beat accounting shared by read and write bursts.
        if ((state_q == S_RD) || (state_q == S_WR)) begin
            if (abort) begin
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                done_d  = 1'b1;
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else if (beat_ok) begin
                if (last_beat) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    adr_d   = adr_next(adr_q, bte_q);
                    beats_d = beats_q - 1'b1;
                    cti_d   = (beats_q > 1) ? 3'b010 : 3'b111;
                end
            end
        end

        to_cnt_d = (stall && stb_d) ? to_cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q      <= S_IDLE;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            cti_q        <= '0;
            bte_q        <= '0;
            beats_q      <= '0;
            to_cnt_q     <= '0;
            rdat_q       <= '0;
            rdat_valid_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            cti_q        <= cti_d;
            bte_q        <= bte_d;
            beats_q      <= beats_d;
            to_cnt_q     <= to_cnt_d;
            rdat_q       <= rdat_d;
            rdat_valid_q <= rdat_valid_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = sel_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = stb_q;
    assign wb.wb_cti_o = cti_q;
    assign wb.wb_bte_o = bte_q;
    assign rdat_valid  = rdat_valid_q;
    assign rdat        = rdat_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: the bench plays the WB slave and checks
// bus and stream outputs against hand-computed values.
module tb_wb_burst_master;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr;
    logic [3:0]  cmd_len;
    logic [1:0]  cmd_bte;
    logic        wdat_valid, wdat_ready;
    logic [31:0] wdat;
    logic [3:0]  wsel;
    logic        rdat_valid;
    logic [31:0] rdat;
    logic        done, err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] a3 [4] = '{32'h2008, 32'h200C, 32'h2000, 32'h2004};

    wb_burst_master_if bus ();

    wb_burst_master #(.LEN_WIDTH(4), .TIMEOUT(8)) dut (
        .wb_clk     (wb_clk),
        .wb_rst_n   (wb_rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_adr    (cmd_adr),
        .cmd_len    (cmd_len),
        .cmd_bte    (cmd_bte),
        .wdat_valid (wdat_valid),
        .wdat_ready (wdat_ready),
        .wdat       (wdat),
        .wsel       (wsel),
        .rdat_valid (rdat_valid),
        .rdat       (rdat),
        .done       (done),
        .err        (err),
        .wb         (bus.master)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic we, input logic [31:0] adr, input logic [3:0] len,
                       input logic [1:0] bte);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_len   = len;
        cmd_bte   = bte;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        wb_rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0;
        cmd_bte = '0; wdat_valid = 1'b0; wdat = '0; wsel = '0;
        bus.wb_dat_i = '0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;
        repeat (3) tick();
        chk("rst_cyc", bus.wb_cyc_o, 0);
        chk("rst_stb", bus.wb_stb_o, 0);
        chk("rst_adr", bus.wb_adr_o, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        wb_rst_n = 1'b1;
        tick();

        // single read, low address bits dropped, ack after two wait cycles
        cmd(1'b0, 32'h0000_0103, 4'd0, 2'b00);
        chk("t1_cyc", bus.wb_cyc_o, 1);
        chk("t1_stb", bus.wb_stb_o, 1);
        chk("t1_adr", bus.wb_adr_o, 32'h100);
        chk("t1_cti", bus.wb_cti_o, 3'b000);
        chk("t1_we", bus.wb_we_o, 0);
        chk("t1_cmd_ready", cmd_ready, 0);
        tick(); tick();
        chk("t1_stb_wait", bus.wb_stb_o, 1);
        chk("t1_rdv_wait", rdat_valid, 0);
        bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hDEAD_BEEF;
        tick();
        bus.wb_ack_i = 1'b0;
        chk("t1_rdv", rdat_valid, 1);
        chk("t1_rdat", rdat, 32'hDEAD_BEEF);
        chk("t1_done", done, 1);
        chk("t1_err", err, 0);
        chk("t1_cyc_end", bus.wb_cyc_o, 0);
        tick();
        chk("t1_done_pulse", done, 0);
        chk("t1_rdv_pulse", rdat_valid, 0);

        // linear 8-beat read burst, slave acks every cycle
        cmd(1'b0, 32'h1000, 4'd7, 2'b00);
        bus.wb_ack_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t2_adr", bus.wb_adr_o, 32'h1000 + 32'(4 * i));
            chk("t2_cti", bus.wb_cti_o, (i < 7) ? 32'd2 : 32'd7);
            chk("t2_stb", bus.wb_stb_o, 1);
            bus.wb_dat_i = 32'hA500_0000 | 32'(i);
            tick();
            chk("t2_rdv", rdat_valid, 1);
            chk("t2_rdat", rdat, 32'hA500_0000 | 32'(i));
            chk("t2_done", done, (i == 7) ? 32'd1 : 32'd0);
        end
        bus.wb_ack_i = 1'b0;
        chk("t2_cyc_end", bus.wb_cyc_o, 0);
        tick();

        // wrap4 write, data always available: no stb gap between beats
        cmd(1'b1, 32'h2008, 4'd3, 2'b01);
        chk("t3_stb_idle", bus.wb_stb_o, 0);
        chk("t3_wrdy", wdat_ready, 1);
        chk("t3_we", bus.wb_we_o, 1);
        chk("t3_bte", bus.wb_bte_o, 2'b01);
        wdat_valid = 1'b1; wdat = 32'h1111_0000; wsel = 4'h1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t3_adr", bus.wb_adr_o, a3[i]);
            chk("t3_stb", bus.wb_stb_o, 1);
            chk("t3_dat", bus.wb_dat_o, 32'h1111_0000 + 32'(i));
            chk("t3_sel", bus.wb_sel_o, 32'(1 << i));
            chk("t3_cti", bus.wb_cti_o, (i < 3) ? 32'd2 : 32'd7);
            bus.wb_ack_i = 1'b1;
            #1;
            chk("t3_wrdy_ack", wdat_ready, (i < 3) ? 32'd1 : 32'd0);
            wdat = 32'h1111_0000 + 32'(i + 1);
            wsel = 4'(1 << (i + 1));
            tick();
        end
        bus.wb_ack_i = 1'b0; wdat_valid = 1'b0;
        chk("t3_done", done, 1);
        chk("t3_err", err, 0);
        chk("t3_cyc_end", bus.wb_cyc_o, 0);
        tick();

        // linear write with data withheld after the first beat
        cmd(1'b1, 32'h3000, 4'd3, 2'b00);
        wdat_valid = 1'b1; wdat = 32'h2222_0000; wsel = 4'hF;
        tick();
        chk("t4_adr0", bus.wb_adr_o, 32'h3000);
        chk("t4_stb0", bus.wb_stb_o, 1);
        wdat_valid = 1'b0; bus.wb_ack_i = 1'b1;
        tick();
        bus.wb_ack_i = 1'b0;
        chk("t4_stb_gap", bus.wb_stb_o, 0);
        chk("t4_cyc_hold", bus.wb_cyc_o, 1);
        chk("t4_adr_adv", bus.wb_adr_o, 32'h3004);
        chk("t4_done_mid", done, 0);
        tick();
        chk("t4_stb_still", bus.wb_stb_o, 0);
        wdat_valid = 1'b1; wdat = 32'h2222_0001;
        tick();
        chk("t4_stb_resume", bus.wb_stb_o, 1);
        for (int i = 1; i < 4; i++) begin
            chk("t4_adr", bus.wb_adr_o, 32'h3000 + 32'(4 * i));
            chk("t4_dat", bus.wb_dat_o, 32'h2222_0000 + 32'(i));
            bus.wb_ack_i = 1'b1;
            wdat = 32'h2222_0000 + 32'(i + 1);
            tick();
            chk("t4_done", done, (i == 3) ? 32'd1 : 32'd0);
        end
        bus.wb_ack_i = 1'b0; wdat_valid = 1'b0;
        chk("t4_cyc_end", bus.wb_cyc_o, 0);
        tick();

        // ack and err together: err wins, no read data
        cmd(1'b0, 32'h7000, 4'd1, 2'b00);
        bus.wb_ack_i = 1'b1; bus.wb_err_i = 1'b1;
        tick();
        bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;
        chk("t7_done", done, 1);
        chk("t7_err", err, 1);
        chk("t7_rdv", rdat_valid, 0);
        chk("t7_cyc", bus.wb_cyc_o, 0);
        tick();

        // slave never acks: abort after 8 stalled cycles
        cmd(1'b0, 32'h4000, 4'd3, 2'b00);
        repeat (7) tick();
        chk("t5_stb_stall", bus.wb_stb_o, 1);
        chk("t5_done_stall", done, 0);
        tick();
        chk("t5_stb_abort", bus.wb_stb_o, 0);
        chk("t5_cyc_abort", bus.wb_cyc_o, 0);
        chk("t5_done", done, 1);
        chk("t5_err", err, 1);
        tick();
        chk("t5_cmd_ready", cmd_ready, 1);
        cmd(1'b0, 32'h4100, 4'd0, 2'b00);
        bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h0BAD_F00D;
        tick();
        bus.wb_ack_i = 1'b0;
        chk("t5_next_done", done, 1);
        chk("t5_next_err", err, 0);
        chk("t5_next_rdat", rdat, 32'h0BAD_F00D);
        tick();

        // reset asserted during beat 3 of an 8-beat read
        cmd(1'b0, 32'h5000, 4'd7, 2'b00);
        bus.wb_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.wb_dat_i = 32'(i);
            tick();
        end
        chk("t6_adr_pre", bus.wb_adr_o, 32'h500C);
        chk("t6_rdv_pre", rdat_valid, 1);
        #2 wb_rst_n = 1'b0;
        #1;
        chk("t6_cyc_rst", bus.wb_cyc_o, 0);
        chk("t6_stb_rst", bus.wb_stb_o, 0);
        chk("t6_done_rst", done, 0);
        chk("t6_rdv_rst", rdat_valid, 0);
        bus.wb_ack_i = 1'b0;
        tick();
        wb_rst_n = 1'b1;
        tick();
        cmd(1'b0, 32'h6000, 4'd0, 2'b00);
        chk("t6_adr_new", bus.wb_adr_o, 32'h6000);
        bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h1234_5678;
        tick();
        bus.wb_ack_i = 1'b0;
        chk("t6_rdv_new", rdat_valid, 1);
        chk("t6_rdat_new", rdat, 32'h1234_5678);
        chk("t6_done_new", done, 1);
        chk("t6_err_new", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
